// File: rtl/branch_update_queue.sv
// ---------------------------------------------------------------------------
// branch_update_queue
//
// In-order tracker for branches that ifetch has predicted but that have not
// resolved yet. ifetch allocates one entry per predicted branch and gets the
// tail index back as a tag. Execution resolves entries out of order by tag.
// Entries retire strictly in allocation order, at most one per cycle. Each
// retire trains the predictor (update/update_pc/update_result). A retire whose
// actual direction differs from the prediction also raises flush/flush_pc and
// empties the whole queue.
//
// Optional feature: define BRANCH_STAT_EN to add the saturating retire and
// mispredict counters stat_total / stat_miss.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   rdy            global ready; low pauses all state changes
//   alloc_valid    ifetch allocates an entry this cycle
//   alloc_pc       pc of the predicted branch
//   alloc_pred     predicted direction (1 = taken)
//   alloc_ready    an entry is free (count < QUEUE_SIZE)
//   alloc_tag      tag handed to an allocation this cycle (tail index)
//   resolve_valid  execution result valid
//   resolve_tag    entry being resolved
//   resolve_taken  actual direction
//   resolve_target actual taken target
//   update         one-cycle predictor training pulse
//   update_pc      pc of the retired branch
//   update_result  actual direction of the retired branch
//   flush          one-cycle misprediction pulse
//   flush_pc       correct next pc after a misprediction
//   count          occupied entries
//   stat_total     (BRANCH_STAT_EN) retired branches, saturating
//   stat_miss      (BRANCH_STAT_EN) mispredicted retires, saturating
// ---------------------------------------------------------------------------
module branch_update_queue #(
  parameter int QUEUE_WIDTH = 3,
  parameter int QUEUE_SIZE  = 1 << QUEUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   alloc_valid,
  input  logic [31:0]            alloc_pc,
  input  logic                   alloc_pred,
  output logic                   alloc_ready,
  output logic [QUEUE_WIDTH-1:0] alloc_tag,
  input  logic                   resolve_valid,
  input  logic [QUEUE_WIDTH-1:0] resolve_tag,
  input  logic                   resolve_taken,
  input  logic [31:0]            resolve_target,
  output logic                   update,
  output logic [31:0]            update_pc,
  output logic                   update_result,
  output logic                   flush,
  output logic [31:0]            flush_pc,
  output logic [QUEUE_WIDTH:0]   count
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0]            stat_total,
  output logic [31:0]            stat_miss
`endif
);

  // Control state (reset)
  logic [QUEUE_SIZE-1:0]  valid_q, valid_d;
  logic [QUEUE_SIZE-1:0]  resolved_q, resolved_d;
  logic [QUEUE_WIDTH-1:0] head_q, head_d;
  logic [QUEUE_WIDTH-1:0] tail_q, tail_d;
  logic [QUEUE_WIDTH:0]   count_q, count_d;
  logic                   update_q, update_d;
  logic [31:0]            update_pc_q, update_pc_d;
  logic                   update_result_q, update_result_d;
  logic                   flush_q, flush_d;
  logic [31:0]            flush_pc_q, flush_pc_d;

  // Entry payload (no reset; only meaningful while the valid bit is set)
  logic [31:0]            pc_q [QUEUE_SIZE];
  logic [31:0]            pc_d [QUEUE_SIZE];
  logic [31:0]            target_q [QUEUE_SIZE];
  logic [31:0]            target_d [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]  pred_q, pred_d;
  logic [QUEUE_SIZE-1:0]  taken_q, taken_d;

  logic do_alloc;
  logic do_resolve;
  logic do_retire;
  logic mispredict;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_total_q, stat_total_d;
  logic [31:0] stat_miss_q, stat_miss_d;
`endif

  // Full/empty come from count, never from head/tail compare, since the
  // pointers are equal both when empty and when full.
  assign alloc_ready = (count_q < (QUEUE_WIDTH+1)'(QUEUE_SIZE));
  assign alloc_tag   = tail_q;

  assign do_alloc   = rdy & alloc_valid & alloc_ready;
  assign do_resolve = rdy & resolve_valid & valid_q[resolve_tag] & ~resolved_q[resolve_tag];
  assign do_retire  = rdy & valid_q[head_q] & resolved_q[head_q];
  assign mispredict = taken_q[head_q] ^ pred_q[head_q];

  always_comb begin
    valid_d         = valid_q;
    resolved_d      = resolved_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    pc_d            = pc_q;
    target_d        = target_q;
    pred_d          = pred_q;
    taken_d         = taken_q;
    update_d        = 1'b0;
    update_pc_d     = update_pc_q;
    update_result_d = update_result_q;
    flush_d         = 1'b0;
    flush_pc_d      = flush_pc_q;

    if (do_resolve) begin
      resolved_d[resolve_tag] = 1'b1;
      taken_d[resolve_tag]    = resolve_taken;
      target_d[resolve_tag]   = resolve_target;
    end

    // The tail slot is always free when alloc_ready is high, so it can never
    // collide with the resolved or retired slot on the same edge.
    if (do_alloc) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      pc_d[tail_q]       = alloc_pc;
      pred_d[tail_q]     = alloc_pred;
      tail_d             = tail_q + QUEUE_WIDTH'(1);
    end

    if (do_retire) begin
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
      head_d             = head_q + QUEUE_WIDTH'(1);
      update_d           = 1'b1;
      update_pc_d        = pc_q[head_q];
      update_result_d    = taken_q[head_q];
    end

    case ({do_alloc, do_retire})
      2'b10:   count_d = count_q + (QUEUE_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (QUEUE_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase

    // A mispredict discards everything younger than the retiring branch,
    // including whatever was allocated or resolved on this same edge.
    if (do_retire && mispredict) begin
      valid_d    = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = taken_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);
    end
  end

`ifdef BRANCH_STAT_EN
  always_comb begin
    stat_total_d = stat_total_q;
    stat_miss_d  = stat_miss_q;
    if (do_retire && (stat_total_q != 32'hFFFF_FFFF)) begin
      stat_total_d = stat_total_q + 32'd1;
    end
    if (do_retire && mispredict && (stat_miss_q != 32'hFFFF_FFFF)) begin
      stat_miss_d = stat_miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_total_q <= '0;
      stat_miss_q  <= '0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_miss_q  <= stat_miss_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_miss  = stat_miss_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q         <= '0;
      resolved_q      <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      update_q        <= 1'b0;
      update_pc_q     <= '0;
      update_result_q <= 1'b0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
    end else begin
      valid_q         <= valid_d;
      resolved_q      <= resolved_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      update_q        <= update_d;
      update_pc_q     <= update_pc_d;
      update_result_q <= update_result_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    target_q <= target_d;
    pred_q   <= pred_d;
    taken_q  <= taken_d;
  end

  assign update        = update_q;
  assign update_pc     = update_pc_q;
  assign update_result = update_result_q;
  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;
  assign count         = count_q;

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- In-order tracker for branches that ifetch has predicted but that are not yet resolved.
- Drives the predictor's training port (update, update_pc, update_result) and the front-end misprediction redirect (flush, flush_pc).
- ifetch allocates an entry per predicted branch and gets back a tag. Execution resolves entries out of order by tag.
- Entries retire strictly in allocation order, at most one per cycle.

Parameters:
QUEUE_WIDTH, 3, log2 of entry count; also the tag width
QUEUE_SIZE, 1 << QUEUE_WIDTH, number of entries

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
rdy  input  1  global ready; low = pause
alloc_valid  input  1  ifetch allocates an entry this cycle
alloc_pc  input  32  branch instruction pc
alloc_pred  input  1  predicted direction, 1 = taken
alloc_ready  output  1  entry available (count < QUEUE_SIZE)
alloc_tag  output  QUEUE_WIDTH  tag given to an allocation this cycle (= tail index)
resolve_valid  input  1  execution result valid
resolve_tag  input  QUEUE_WIDTH  entry being resolved
resolve_taken  input  1  actual direction
resolve_target  input  32  actual taken target
update  output  1  one-cycle predictor training pulse
update_pc  output  32  pc of retired branch
update_result  output  1  actual direction of retired branch
flush  output  1  one-cycle misprediction pulse
flush_pc  output  32  correct next pc
count  output  QUEUE_WIDTH+1  occupied entries

Behaviour:
- Reset (rst low, async): head = tail = 0, count = 0, all valid/resolved bits cleared. update, update_pc, update_result, flush, flush_pc all 0.
- Per-entry state: valid, resolved, pc, pred, taken, target.
- alloc_ready and alloc_tag are combinational from registered state. alloc_ready = (count < QUEUE_SIZE); it does not count a same-cycle retire.
- Allocation: on an edge with rdy & alloc_valid & alloc_ready, the entry at tail is written with valid = 1 and resolved = 0; tail increments modulo QUEUE_SIZE. alloc_valid while full is ignored.
- Resolution: on an edge with rdy & resolve_valid, if entry[resolve_tag] is valid and not yet resolved, it stores taken/target and sets resolved = 1. A resolve to an invalid or already-resolved entry is ignored.
- Retire: on an edge with rdy, if the head entry is valid and resolved (as registered):
  - it is cleared and head increments;
  - update = 1, update_pc = pc, update_result = taken, all registered and high for exactly one cycle;
  - mispredict = (taken != pred).
- Latency: a resolve of the head entry sampled at edge N sets resolved; update is visible after edge N+1.
- Mispredict on retire:
  - flush = 1 in the same cycle as update;
  - flush_pc = taken ? target : pc + 4 (32-bit wrap);
  - on that same edge all entries are invalidated, head = tail = 0, count = 0;
  - same-edge allocations and resolutions are discarded.
- Non-retiring edge with rdy high: update and flush = 0. update_pc, update_result and flush_pc hold.
- count: +1 on allocate, -1 on retire, both on one edge = unchanged, 0 after flush.
- Wrap-around: head and tail wrap modulo QUEUE_SIZE; full/empty are taken from count, not from pointer compare.
- rdy low: no allocation, resolution or retire; update and flush forced to 0; all other state holds.
- Reset mid-operation clears everything immediately, including any pulse in flight.

Optional Feature:
- Macro: BRANCH_STAT_EN.
- Defined:
  - extra output ports stat_total (32) and stat_miss (32), both reset to 0;
  - stat_total increments on every retire, stat_miss on every mispredicting retire;
  - both saturate at 32'hFFFFFFFF and freeze while rdy is low.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle -> alloc_ready = 1, alloc_tag = 0, count = 0, update = flush = 0.
- Alloc pc 0x100 pred 1 (tag 0); resolve tag 0 taken = 1 target 0x80 -> update pulse: update_pc 0x100, update_result 1, flush 0, count back to 0.
- Alloc 0x200 pred 0 (tag 0) and 0x204 pred 0 (tag 1); resolve tag 1 not-taken first, then tag 0 not-taken -> two consecutive update pulses in order 0x200 then 0x204, no flush.
- Alloc 0x300 pred 0 and 0x304 pred 1; resolve tag 0 taken target 0x400 -> update + flush, flush_pc 0x400, count 0, tag 1 discarded; next alloc_tag 0.
- Fill 8 entries -> alloc_ready 0, 9th alloc ignored. Resolve the head -> after retire count 7, alloc_ready 1; alloc and retire on one edge -> count unchanged; tail wraps to 0.
- Mispredict with pred 1, taken 0, pc 0xFFFFFFFC -> flush_pc 0x00000000. Drop rdy for 3 cycles mid-stream -> no pulses and no state change; resumes exactly.
